wb_stage: RTL and testbench

- Write-back stage that sits directly upstream of the 8x16 register file and drives its single write port (writeregsel, writedata, write).
- Buffers results from the memory stage in an in-order queue. ALU results arrive complete; load results are filled in later by the data-memory return path.
- Retires one entry per cycle into the register file.
- Gives decode forwarding data and stall information for the two register-file read selects.

---
 rtl/wb_stage_if.sv | 42 ++++
 rtl/wb_stage.sv | 152 +++++++++++++++
 tb/tb_wb_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bus interface for wb_stage: memory-stage push, load-data return,
// register-file write port and decode forwarding/stall signals.
//   master : memory stage / decode side (drives pushes, loads, read selects)
//   slave  : wb_stage (drives in_ready, register-file write, forwarding, err)
interface wb_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic [REG_AW-1:0] in_dest;
  logic              in_is_load;
  logic [DATA_W-1:0] in_data;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic [REG_AW-1:0] writeregsel;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic [REG_AW-1:0] read1regsel;
  logic [REG_AW-1:0] read2regsel;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic              raw_stall;
  logic              err;

  modport master (
    output in_valid, in_regwrite, in_dest, in_is_load, in_data,
    output ld_valid, ld_data, read1regsel, read2regsel,
    input  in_ready, writeregsel, writedata, write,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, raw_stall, err
  );

  modport slave (
    input  in_valid, in_regwrite, in_dest, in_is_load, in_data,
    input  ld_valid, ld_data, read1regsel, read2regsel,
    output in_ready, writeregsel, writedata, write,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, raw_stall, err
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: in-order result queue feeding the register-file write
// port, with load data filled in later and decode forwarding/interlock.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - wb_stage_if.slave (push, load return, RF write, forwarding, err)
// Build option: define WB_FWD_EN to enable forwarding; otherwise fwd outputs
// are tied to 0 and raw_stall interlocks on any pending write to a read select.
module wb_stage #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic   clk,
  input  logic   rst,
  wb_stage_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  e_valid, e_regwrite, e_is_load, e_filled;
  logic [REG_AW-1:0] e_dest [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic              err_q;

  logic              full, push, pop;
  logic              fill_found;
  logic [PTR_W-1:0]  fill_ptr_c;

  // Queue status and handshake
  assign full         = (count == CNT_W'(DEPTH));
  assign push         = bus.in_valid & ~full;
  assign pop          = (count != '0) & e_filled[head];
  assign bus.in_ready = ~full;

  // Register-file write port straight from the head entry
  assign bus.write       = pop & e_regwrite[head];
  assign bus.writeregsel = (count != '0) ? e_dest[head] : '0;
  assign bus.writedata   = (count != '0) ? e_data[head] : '0;
  assign bus.err         = err_q;

  // Fill pointer: oldest valid load still waiting for data
  always_comb begin
    fill_found = 1'b0;
    fill_ptr_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!fill_found && e_valid[PTR_W'(head + PTR_W'(i))] &&
          e_is_load[PTR_W'(head + PTR_W'(i))] &&
          !e_filled[PTR_W'(head + PTR_W'(i))]) begin
        fill_found = 1'b1;
        fill_ptr_c = PTR_W'(head + PTR_W'(i));
      end
    end
  end

`ifdef WB_FWD_EN
  logic              m1_hit, m1_filled, m2_hit, m2_filled;
  logic [DATA_W-1:0] m1_data, m2_data;

  // Scan oldest to newest so the newest matching entry wins
  always_comb begin
    m1_hit    = 1'b0;
    m1_filled = 1'b0;
    m1_data   = '0;
    m2_hit    = 1'b0;
    m2_filled = 1'b0;
    m2_data   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (e_valid[PTR_W'(head + PTR_W'(i))] && e_regwrite[PTR_W'(head + PTR_W'(i))]) begin
        if (e_dest[PTR_W'(head + PTR_W'(i))] == bus.read1regsel) begin
          m1_hit    = 1'b1;
          m1_filled = e_filled[PTR_W'(head + PTR_W'(i))];
          m1_data   = e_data[PTR_W'(head + PTR_W'(i))];
        end
        if (e_dest[PTR_W'(head + PTR_W'(i))] == bus.read2regsel) begin
          m2_hit    = 1'b1;
          m2_filled = e_filled[PTR_W'(head + PTR_W'(i))];
          m2_data   = e_data[PTR_W'(head + PTR_W'(i))];
        end
      end
    end
  end

  // An unfilled newest match cannot forward, so decode must wait
  assign bus.fwd1_hit  = m1_hit & m1_filled;
  assign bus.fwd1_data = (m1_hit & m1_filled) ? m1_data : '0;
  assign bus.fwd2_hit  = m2_hit & m2_filled;
  assign bus.fwd2_data = (m2_hit & m2_filled) ? m2_data : '0;
  assign bus.raw_stall = (m1_hit & ~m1_filled) | (m2_hit & ~m2_filled);
`else
  logic any_match;

  // Pure scoreboard interlock: any pending write to either select stalls
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (e_valid[i] && e_regwrite[i] &&
          ((e_dest[i] == bus.read1regsel) || (e_dest[i] == bus.read2regsel))) begin
        any_match = 1'b1;
      end
    end
  end

  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd2_data = '0;
  assign bus.raw_stall = any_match;
`endif

  // Queue state; push, fill and pop never target the same slot in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      e_valid    <= '0;
      e_regwrite <= '0;
      e_is_load  <= '0;
      e_filled   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        e_dest[i] <= '0;
        e_data[i] <= '0;
      end
    end else begin
      err_q <= (bus.ld_valid & ~fill_found) | (bus.in_valid & full);
      if (push) begin
        e_valid[tail]    <= 1'b1;
        e_regwrite[tail] <= bus.in_regwrite;
        e_is_load[tail]  <= bus.in_is_load;
        e_filled[tail]   <= ~bus.in_is_load;
        e_dest[tail]     <= bus.in_dest;
        e_data[tail]     <= bus.in_is_load ? '0 : bus.in_data;
        tail             <= PTR_W'(tail + PTR_W'(1));
      end
      if (bus.ld_valid && fill_found) begin
        e_filled[fill_ptr_c] <= 1'b1;
        e_data[fill_ptr_c]   <= bus.ld_data;
      end
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= PTR_W'(head + PTR_W'(1));
      end
      count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed stimulus, expected register writes pushed
// to a scoreboard and checked by an independent monitor; status outputs
// (forwarding, stall, ready, err) checked directly against constants.
module tb_wb_stage;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  sb[$];

  wb_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_alu(input logic [REG_AW-1:0] d, input logic [DATA_W-1:0] v);
    bus.in_valid    = 1'b1;
    bus.in_regwrite = 1'b1;
    bus.in_dest     = d;
    bus.in_is_load  = 1'b0;
    bus.in_data     = v;
    sb.push_back('{dest: d, data: v});
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Caller pushes the expected write when the load data value is known
  task automatic push_load(input logic [REG_AW-1:0] d);
    bus.in_valid    = 1'b1;
    bus.in_regwrite = 1'b1;
    bus.in_dest     = d;
    bus.in_is_load  = 1'b1;
    bus.in_data     = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic fill(input logic [DATA_W-1:0] v);
    bus.ld_valid = 1'b1;
    bus.ld_data  = v;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  // Monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (rst && bus.write) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected actual=r%0d:%0h expected=none",
                 bus.writeregsel, bus.writedata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (bus.writeregsel !== e.dest || bus.writedata !== e.data) begin
          errors++;
          $display("FAIL rf_write actual=r%0d:%0h expected=r%0d:%0h",
                   bus.writeregsel, bus.writedata, e.dest, e.data);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_regwrite = 1'b0; bus.in_dest = '0;
    bus.in_is_load = 1'b0; bus.in_data = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0;
    bus.read1regsel = 3'd0; bus.read2regsel = 3'd0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_writedata", 32'(bus.writedata), 32'd0);
    chk("rst_raw_stall", 32'(bus.raw_stall), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    tick();
    rst = 1'b1;

    // 1: reset mid-queue discards pending loads
    bus.read1regsel = 3'd2;
    push_load(3'd1); push_load(3'd2); push_load(3'd3);
    @(negedge clk);
    chk("t1_stall_before", 32'(bus.raw_stall), 32'd1);
    chk("t1_write_before", 32'(bus.write), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t1_stall_in_rst", 32'(bus.raw_stall), 32'd0);
    chk("t1_ready_in_rst", 32'(bus.in_ready), 32'd1);
    chk("t1_write_in_rst", 32'(bus.write), 32'd0);
    tick();
    rst = 1'b1;
    fill(16'hAAAA);
    @(negedge clk);
    chk("t1_err_orphan_ld", 32'(bus.err), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_err_clears", 32'(bus.err), 32'd0);

    // 2/6: ALU result writes one cycle after push and forwards meanwhile
    bus.read1regsel = 3'd3;
    push_alu(3'd3, 16'h1234);
    @(negedge clk);
    chk("t2_write", 32'(bus.write), 32'd1);
    chk("t2_writeregsel", 32'(bus.writeregsel), 32'd3);
`ifdef WB_FWD_EN
    chk("t2_fwd1_hit", 32'(bus.fwd1_hit), 32'd1);
    chk("t2_fwd1_data", 32'(bus.fwd1_data), 32'h1234);
    chk("t2_raw_stall", 32'(bus.raw_stall), 32'd0);
`else
    chk("t6_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
    chk("t6_fwd1_data", 32'(bus.fwd1_data), 32'd0);
    chk("t6_raw_stall", 32'(bus.raw_stall), 32'd1);
`endif
    tick();
    @(negedge clk);
    chk("t2_fwd1_hit_after", 32'(bus.fwd1_hit), 32'd0);
    chk("t2_stall_after", 32'(bus.raw_stall), 32'd0);
    chk("t2_write_after", 32'(bus.write), 32'd0);

    // 3: unfilled load blocks the head; fill releases in order
    bus.read1regsel = 3'd5;
    bus.read2regsel = 3'd2;
    push_load(3'd5);
    sb.push_back('{dest: 3'd5, data: 16'hBEEF});
    push_alu(3'd2, 16'h2222);
    @(negedge clk);
    chk("t3_head_blocked", 32'(bus.write), 32'd0);
    chk("t3_raw_stall", 32'(bus.raw_stall), 32'd1);
    chk("t3_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
`ifdef WB_FWD_EN
    chk("t3_fwd2_hit", 32'(bus.fwd2_hit), 32'd1);
    chk("t3_fwd2_data", 32'(bus.fwd2_data), 32'h2222);
`else
    chk("t3_fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
`endif
    fill(16'hBEEF);
    @(negedge clk);
    chk("t3_write_r5", 32'(bus.write), 32'd1);
    chk("t3_writeregsel_r5", 32'(bus.writeregsel), 32'd5);
`ifdef WB_FWD_EN
    chk("t3_fwd1_filled", 32'(bus.fwd1_data), 32'hBEEF);
    chk("t3_stall_filled", 32'(bus.raw_stall), 32'd0);
`else
    chk("t3_stall_filled", 32'(bus.raw_stall), 32'd1);
`endif
    tick();
    @(negedge clk);
    chk("t3_write_r2", 32'(bus.write), 32'd1);
    chk("t3_writeregsel_r2", 32'(bus.writeregsel), 32'd2);
    drain("t3");

    // 4: newest of two matching entries forwards
    bus.read1regsel = 3'd7;
    bus.read2regsel = 3'd4;
    push_load(3'd7);
    sb.push_back('{dest: 3'd7, data: 16'h7777});
    push_alu(3'd4, 16'h0001);
    push_alu(3'd4, 16'h0002);
    @(negedge clk);
    chk("t4_raw_stall", 32'(bus.raw_stall), 32'd1);
`ifdef WB_FWD_EN
    chk("t4_fwd2_hit", 32'(bus.fwd2_hit), 32'd1);
    chk("t4_fwd2_newest", 32'(bus.fwd2_data), 32'h0002);
`else
    chk("t4_fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
`endif
    fill(16'h7777);
    drain("t4");

    // 5: full queue drops extra push, then drains with wrap and push+pop
    bus.read1regsel = 3'd6;
    bus.read2regsel = 3'd0;
    push_load(3'd6);
    sb.push_back('{dest: 3'd6, data: 16'h6666});
    push_alu(3'd1, 16'h0011);
    push_alu(3'd2, 16'h0022);
    push_alu(3'd3, 16'h0033);
    @(negedge clk);
    chk("t5_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_full_stall", 32'(bus.raw_stall), 32'd1);
    bus.in_valid = 1'b1; bus.in_regwrite = 1'b1; bus.in_dest = 3'd0;
    bus.in_is_load = 1'b0; bus.in_data = 16'hDEAD;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_overflow", 32'(bus.err), 32'd1);
    chk("t5_still_full", 32'(bus.in_ready), 32'd0);
    fill(16'h6666);
    @(negedge clk);
    chk("t5_err_clears", 32'(bus.err), 32'd0);
    chk("t5_drain_r6", 32'(bus.writeregsel), 32'd6);
    tick();
    @(negedge clk);
    chk("t5_ready_after_pop", 32'(bus.in_ready), 32'd1);
    chk("t5_drain_1", 32'(bus.write), 32'd1);
    push_alu(3'd5, 16'h0055);
    @(negedge clk);
    chk("t5_drain_2", 32'(bus.write), 32'd1);
    chk("t5_drain_2_sel", 32'(bus.writeregsel), 32'd2);
    drain("t5");
    chk("t5_empty_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_empty_write", 32'(bus.write), 32'd0);
    chk("t5_empty_writedata", 32'(bus.writedata), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
